// File: rtl/alu_ctrl_pipe_if.sv
// Handshake bundle between the instruction-field source, the ALU control decoder and the ALU stage.
// slave = decoder view, master = producer/consumer view.
interface alu_ctrl_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ALUControl;
  logic       use_shamt;
  logic       illegal;
  logic [7:0] illegal_count;

  modport slave (
    input  in_valid, opcode, funct, out_ready,
    output in_ready, out_valid, ALUControl, use_shamt, illegal, illegal_count
  );

  modport master (
    output in_valid, opcode, funct, out_ready,
    input  in_ready, out_valid, ALUControl, use_shamt, illegal, illegal_count
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// ALU control decode into a 2-entry skid FIFO; 1-cycle latency, registered in_ready drops when full.
// Optional ALU_CTRL_VAR_SHIFT_EN adds register-amount shifts (funct 0x04/0x06/0x07).
module alu_ctrl_pipe (
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_pipe_if.slave   bus
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       use_shamt;
    logic       illegal;
  } dec_t;

  localparam dec_t DEC_NONE = '{alu_ctrl: ALU_ADD, use_shamt: 1'b0, illegal: 1'b0};

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = DEC_NONE;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: d.alu_ctrl = ALU_ADD;
        6'h22, 6'h23: d.alu_ctrl = ALU_SUB;
        6'h24:        d.alu_ctrl = ALU_AND;
        6'h25:        d.alu_ctrl = ALU_OR;
        6'h26:        d.alu_ctrl = ALU_XOR;
        6'h00: begin d.alu_ctrl = ALU_SLL; d.use_shamt = 1'b1; end
        6'h02: begin d.alu_ctrl = ALU_SRL; d.use_shamt = 1'b1; end
        6'h03: begin d.alu_ctrl = ALU_SRA; d.use_shamt = 1'b1; end
`ifdef ALU_CTRL_VAR_SHIFT_EN
        // Shift amount comes from a register, so the B operand is not shamt.
        6'h04:        d.alu_ctrl = ALU_SLL;
        6'h06:        d.alu_ctrl = ALU_SRL;
        6'h07:        d.alu_ctrl = ALU_SRA;
`endif
        default:      d.illegal = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: d.alu_ctrl = ALU_ADD;
        6'h04, 6'h05:               d.alu_ctrl = ALU_SUB;
        6'h0C:                      d.alu_ctrl = ALU_AND;
        6'h0D:                      d.alu_ctrl = ALU_OR;
        6'h0E:                      d.alu_ctrl = ALU_XOR;
        6'h0F:                      d.alu_ctrl = ALU_LUI;
        default:                    d.illegal  = 1'b1;
      endcase
    end
    return d;
  endfunction

  dec_t       head_q, head_d;
  dec_t       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] illegal_count_q, illegal_count_d;

  dec_t       in_dec;
  logic       push;
  logic       pop;

  assign in_dec = decode(bus.opcode, bus.funct);

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    cnt_d           = cnt_q;
    illegal_count_d = illegal_count_q;

    // in_ready_q is already low when full, so a pop never frees a slot for the same edge.
    push = bus.in_valid && in_ready_q;
    pop  = (cnt_q != 2'd0) && bus.out_ready;

    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_dec;
        else               tail_d = in_dec;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Emptied slots are zeroed so the outputs read 0 whenever out_valid is low.
        head_d = (cnt_q == 2'd2) ? tail_q : DEC_NONE;
        tail_d = DEC_NONE;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        head_d = in_dec;
      end
      default: ;
    endcase

    if (pop && head_q.illegal && (illegal_count_q != 8'hFF))
      illegal_count_d = illegal_count_q + 8'd1;

    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q          <= DEC_NONE;
      tail_q          <= DEC_NONE;
      cnt_q           <= 2'd0;
      in_ready_q      <= 1'b0;
      illegal_count_q <= 8'd0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      cnt_q           <= cnt_d;
      in_ready_q      <= in_ready_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = (cnt_q != 2'd0);
  assign bus.ALUControl    = head_q.alu_ctrl;
  assign bus.use_shamt     = head_q.use_shamt;
  assign bus.illegal       = head_q.illegal;
  assign bus.illegal_count = illegal_count_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: directed scenarios plus random traffic against a queue-based reference.
module tb_alu_ctrl_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_ctrl_pipe_if bus ();

  alu_ctrl_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: queue of {alu[3:0], use_shamt, illegal}
  logic [5:0] mq[$];
  logic       m_rdy;
  int         m_cnt;

  function automatic logic [5:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) return {4'd0, 2'b00};
      if (fn == 6'h22 || fn == 6'h23) return {4'd1, 2'b00};
      if (fn == 6'h24) return {4'd2, 2'b00};
      if (fn == 6'h25) return {4'd3, 2'b00};
      if (fn == 6'h26) return {4'd4, 2'b00};
      if (fn == 6'h00) return {4'd6, 2'b10};
      if (fn == 6'h02) return {4'd7, 2'b10};
      if (fn == 6'h03) return {4'd8, 2'b10};
`ifdef ALU_CTRL_VAR_SHIFT_EN
      if (fn == 6'h04) return {4'd6, 2'b00};
      if (fn == 6'h06) return {4'd7, 2'b00};
      if (fn == 6'h07) return {4'd8, 2'b00};
`endif
      return {4'd0, 2'b01};
    end
    if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B) return {4'd0, 2'b00};
    if (op == 6'h04 || op == 6'h05) return {4'd1, 2'b00};
    if (op == 6'h0C) return {4'd2, 2'b00};
    if (op == 6'h0D) return {4'd3, 2'b00};
    if (op == 6'h0E) return {4'd4, 2'b00};
    if (op == 6'h0F) return {4'd5, 2'b00};
    return {4'd0, 2'b01};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [5:0] h;
    h = (mq.size() != 0) ? mq[0] : 6'd0;
    chk("in_ready",      32'(bus.in_ready),      32'(m_rdy));
    chk("out_valid",     32'(bus.out_valid),     32'(mq.size() != 0));
    chk("ALUControl",    32'(bus.ALUControl),    32'(h[5:2]));
    chk("use_shamt",     32'(bus.use_shamt),     32'(h[1]));
    chk("illegal",       32'(bus.illegal),       32'(h[0]));
    chk("illegal_count", 32'(bus.illegal_count), 32'(m_cnt));
  endtask

  // One clock: drive, advance past the edge, update the reference, compare.
  task automatic cycle(input logic iv, input logic [5:0] op, input logic [5:0] fn,
                       input logic ordy, output logic acc);
    logic push, pop;
    logic [5:0] h;
    bus.in_valid  = iv;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.out_ready = ordy;
    push = iv && m_rdy;
    pop  = (mq.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (pop) begin
      h = mq.pop_front();
      if (h[0] && m_cnt < 255) m_cnt++;
    end
    if (push) mq.push_back(ref_decode(op, fn));
    m_rdy = (mq.size() < 2);
    acc = push;
    check_outputs();
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    logic       acc;
    logic       hold;
    logic [5:0] op, fn;
    logic       ordy;

    bus.in_valid  = 1'b0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.out_ready = 1'b0;
    model_reset();

    // Power-on reset
    #1 rst = 1'b1;
    #1 check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check_outputs();
    cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);
    chk("rdy_after_reset", 32'(bus.in_ready), 32'd1);

    // Single SUB, 1-cycle latency
    cycle(1'b1, 6'h00, 6'h22, 1'b1, acc);
    chk("sub_valid", 32'(bus.out_valid), 32'd1);
    chk("sub_alu",   32'(bus.ALUControl), 32'd1);
    cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);

    // Backpressure: LUI, OR fill the FIFO; AND is held off
    cycle(1'b1, 6'h0F, 6'h00, 1'b0, acc);
    cycle(1'b1, 6'h0D, 6'h00, 1'b0, acc);
    chk("full_rdy_low", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, 6'h0C, 6'h00, 1'b0, acc);
    chk("third_held", 32'(acc), 32'd0);
    chk("head_lui", 32'(bus.ALUControl), 32'd5);
    cycle(1'b1, 6'h0C, 6'h00, 1'b1, acc);
    chk("pop_full_no_push", 32'(acc), 32'd0);
    chk("head_or", 32'(bus.ALUControl), 32'd3);
    cycle(1'b1, 6'h0C, 6'h00, 1'b1, acc);
    chk("and_accepted", 32'(acc), 32'd1);
    chk("head_and", 32'(bus.ALUControl), 32'd2);
    cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);
    chk("drained", 32'(bus.out_valid), 32'd0);

    // SRA with shamt, then an illegal opcode
    cycle(1'b1, 6'h00, 6'h03, 1'b0, acc);
    chk("sra_alu",   32'(bus.ALUControl), 32'd8);
    chk("sra_shamt", 32'(bus.use_shamt), 32'd1);
    cycle(1'b1, 6'h3F, 6'h00, 1'b1, acc);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);
    chk("ill_count_one", 32'(bus.illegal_count), 32'd1);

    // Variable shift funct 0x07 (illegal unless the option is built in)
    cycle(1'b1, 6'h00, 6'h07, 1'b1, acc);
`ifdef ALU_CTRL_VAR_SHIFT_EN
    chk("varshift_alu", 32'(bus.ALUControl), 32'd8);
    chk("varshift_ill", 32'(bus.illegal), 32'd0);
`else
    chk("varshift_ill", 32'(bus.illegal), 32'd1);
`endif
    cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);

    // Async reset while two entries are held
    cycle(1'b1, 6'h08, 6'h00, 1'b0, acc);
    cycle(1'b1, 6'h0E, 6'h00, 1'b0, acc);
    #3 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);
    chk("empty_after_rst", 32'(bus.out_valid), 32'd0);

    // Random traffic; fields held stable until accepted
    hold = 1'b0;
    op = 6'd0;
    fn = 6'd0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        if ($urandom_range(1) == 0) begin
          op = 6'h00;
          fn = 6'($urandom_range(63));
        end else begin
          op = 6'($urandom_range(63));
          fn = 6'($urandom_range(63));
        end
      end
      hold = ($urandom_range(3) != 0) || hold;
      ordy = ($urandom_range(9) < 7);
      cycle(hold, op, fn, ordy, acc);
      if (acc) hold = 1'b0;
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);

    // Saturation of the illegal counter
    for (int i = 0; i < 300; i++) cycle(1'b1, 6'h3F, 6'h00, 1'b1, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'h00, 6'h00, 1'b1, acc);
    chk("ill_saturated", 32'(bus.illegal_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
